// File: rtl/lab62_soc_key_poller_if.sv
// ---------------------------------------------------------------------------
// lab62_soc_key_poller_if
//   Avalon-MM read-only bus between the key poller (master) and the key PIO
//   slave.
//   avm_address      master -> slave  word address
//   avm_read         master -> slave  read request
//   avm_waitrequest  slave  -> master stall
//   avm_readdata     slave  -> master read data (fixed latency after accept)
// ---------------------------------------------------------------------------
interface lab62_soc_key_poller_if #(
  parameter int unsigned ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/lab62_soc_key_poller.sv
// ---------------------------------------------------------------------------
// lab62_soc_key_poller
//   Avalon-MM read master that periodically reads the key PIO register,
//   debounces the low KEY_W bits and publishes a stable key state with
//   one-cycle rise/fall pulses, so key handling needs no CPU polling.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       1 = polling runs; 0 = no new reads are issued
//   avm          Avalon-MM master side (address, read, waitrequest, readdata)
//   key_state    debounced key value
//   key_rise     one-cycle pulse per bit on a 0->1 change of key_state
//   key_fall     one-cycle pulse per bit on a 1->0 change of key_state
//   busy         high from read issue until the sample has been evaluated
//   timeout_err  (KEY_POLL_TIMEOUT_EN only) sticky: a read was never accepted
//
// Build option
//   KEY_POLL_TIMEOUT_EN  adds TIMEOUT_CYCLES and timeout_err; a request that
//                        is not accepted within TIMEOUT_CYCLES is abandoned.
// ---------------------------------------------------------------------------
module lab62_soc_key_poller #(
  parameter int unsigned KEY_W        = 2,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned POLL_ADDR    = 0,
  parameter int unsigned POLL_CYCLES  = 50000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STABLE_N     = 3
`ifdef KEY_POLL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  lab62_soc_key_poller_if.master        avm,
  output logic [KEY_W-1:0]              key_state,
  output logic [KEY_W-1:0]              key_rise,
  output logic [KEY_W-1:0]              key_fall,
  output logic                          busy
`ifdef KEY_POLL_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int unsigned TMR_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_N + 1);

  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_N);

`ifdef KEY_POLL_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LAT,
    EVAL
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [KEY_W-1:0]   sample_q, sample_d;
  logic [KEY_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_new;
  logic [KEY_W-1:0]   key_state_q, key_state_d;
  logic [KEY_W-1:0]   key_rise_q, key_rise_d;
  logic [KEY_W-1:0]   key_fall_q, key_fall_d;
  logic               tick;
`ifdef KEY_POLL_TIMEOUT_EN
  logic [TO_W-1:0]    to_q, to_d;
  logic               err_q, err_d;
`endif

  // Upper readdata bits carry nothing of interest to the poller.
  if (KEY_W < 32) begin : g_hi_bits
    logic unused_readdata_hi;
    assign unused_readdata_hi = ^avm.avm_readdata[31:KEY_W];
  end

  // Poll timer: held at 0 while disabled so the first read after enable
  // rises lands a full POLL_CYCLES later.
  always_comb begin
    timer_d = '0;
    if (enable && (timer_q != TMR_LAST)) begin
      timer_d = timer_q + 1'b1;
    end
    tick = enable && (timer_q == TMR_LAST);
  end

  // Next-state and read-path logic. A tick outside IDLE is simply ignored.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    sample_d = sample_q;
`ifdef KEY_POLL_TIMEOUT_EN
    to_d     = to_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = REQ;
`ifdef KEY_POLL_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      REQ: begin
        if (!avm.avm_waitrequest) begin
          state_d = LAT;
          lat_d   = '0;
        end
`ifdef KEY_POLL_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      LAT: begin
        if (lat_q == LAT_LAST) begin
          sample_d = avm.avm_readdata[KEY_W-1:0];
          state_d  = EVAL;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      EVAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Debounce: evaluated once per completed read, while in EVAL.
  always_comb begin
    cnt_d       = cnt_q;
    last_d      = last_q;
    key_state_d = key_state_q;
    key_rise_d  = '0;
    key_fall_d  = '0;
    cnt_new     = cnt_q;
    if (state_q == EVAL) begin
      if (sample_q == last_q) begin
        cnt_new = (cnt_q >= STABLE_MAX) ? STABLE_MAX : cnt_q + 1'b1;
      end else begin
        cnt_new = CNT_W'(1);
      end
      cnt_d  = cnt_new;
      last_d = sample_q;
      if ((cnt_new >= STABLE_MAX) && (sample_q != key_state_q)) begin
        key_state_d = sample_q;
        key_rise_d  = sample_q & ~key_state_q;
        key_fall_d  = ~sample_q & key_state_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      lat_q       <= '0;
      sample_q    <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      key_state_q <= '0;
      key_rise_q  <= '0;
      key_fall_q  <= '0;
`ifdef KEY_POLL_TIMEOUT_EN
      to_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lat_q       <= lat_d;
      sample_q    <= sample_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      key_rise_q  <= key_rise_d;
      key_fall_q  <= key_fall_d;
`ifdef KEY_POLL_TIMEOUT_EN
      to_q        <= to_d;
      err_q       <= err_d;
`endif
    end
  end

  // Outputs decode the registered state, so avm_read falls with reset.
  always_comb begin
    avm.avm_address = ADDR_W'(POLL_ADDR);
    avm.avm_read    = (state_q == REQ);
    busy            = (state_q != IDLE);
    key_state       = key_state_q;
    key_rise        = key_rise_q;
    key_fall        = key_fall_q;
`ifdef KEY_POLL_TIMEOUT_EN
    timeout_err     = err_q;
`endif
  end

endmodule

// File: tb/tb_lab62_soc_key_poller.sv
module tb_lab62_soc_key_poller;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] key_state, key_rise, key_fall;
  logic       busy;
`ifdef KEY_POLL_TIMEOUT_EN
  logic       timeout_err;
`endif

  lab62_soc_key_poller_if #(.ADDR_W(2)) avm_if ();

  lab62_soc_key_poller #(
    .KEY_W(2),
    .ADDR_W(2),
    .POLL_ADDR(2),
    .POLL_CYCLES(8),
    .READ_LATENCY(1),
    .STABLE_N(3)
`ifdef KEY_POLL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .avm(avm_if),
    .key_state(key_state),
    .key_rise(key_rise),
    .key_fall(key_fall),
    .busy(busy)
`ifdef KEY_POLL_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Slave model: stalls stall_cfg cycles, returns key data exactly one cycle
  // after acceptance and inverted low bits on every other cycle.
  logic [1:0]  key_val = 2'b00;
  int unsigned stall_cfg = 0;
  int unsigned wcnt = 0;
  logic [31:0] rdata = '0;

  assign avm_if.avm_waitrequest = avm_if.avm_read && (wcnt < stall_cfg);
  assign avm_if.avm_readdata    = rdata;

  always @(posedge clk) begin
    if (avm_if.avm_read && avm_if.avm_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (avm_if.avm_read && !avm_if.avm_waitrequest) rdata <= {30'h25A5_A5A5, key_val};
    else rdata <= {30'h3FFF_FFFF, ~key_val};
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse / read-issue monitor.
  int unsigned rise_cnt = 0, fall_cnt = 0, read_starts = 0;
  logic [1:0]  last_rise = '0, last_fall = '0;
  logic        prev_read = 1'b0;
  always @(negedge clk) begin
    if (key_rise != 0) begin rise_cnt++; last_rise = key_rise; end
    if (key_fall != 0) begin fall_cnt++; last_fall = key_fall; end
    if (avm_if.avm_read && !prev_read) read_starts++;
    prev_read = avm_if.avm_read;
  end

  int unsigned checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One full poll: wait for the read, measure read and busy length.
  task automatic do_poll(input logic [1:0] key, input int unsigned stall, input bit drop_en,
                         output int unsigned start, output int unsigned len,
                         output int unsigned blen);
    int unsigned n = 0;
    key_val   = key;
    stall_cfg = stall;
    while (!avm_if.avm_read && n < 40) begin step(); n++; end
    chk("read_issue", {31'd0, avm_if.avm_read}, 1);
    chk("address", {30'd0, avm_if.avm_address}, 2);
    start = cyc;
    if (drop_en) enable = 1'b0;
    len = 0;
    blen = 0;
    while (avm_if.avm_read && len < 100) begin len++; blen++; step(); end
    while (busy && blen < 200) begin blen++; step(); end
  endtask

  int unsigned s, l, b, prev_s, en_cyc, rs;

  initial begin
    // Reset state
    step();
    chk("reset_outs", {27'd0, avm_if.avm_read, busy, key_state, key_rise[0] | key_fall[0]}, 0);
    chk("reset_pulses", {28'd0, key_rise, key_fall}, 0);

    // 1. steady 00: one-cycle read every 8 cycles, no change
    reset_n = 1'b1;
    enable  = 1'b1;
    en_cyc  = cyc;
    do_poll(2'b00, 0, 0, s, l, b);
    chk("t1_first_issue", s - en_cyc, 8);
    chk("t1_len", l, 1);
    chk("t1_busy_len", b, 3);
    prev_s = s;
    for (int i = 0; i < 2; i++) begin
      do_poll(2'b00, 0, 0, s, l, b);
      chk("t1_period", s - prev_s, 8);
      prev_s = s;
    end
    chk("t1_state", {30'd0, key_state}, 0);
    chk("t1_no_pulse", rise_cnt + fall_cnt, 0);

    // 2. 00 -> 01 held: accepted on the third read
    do_poll(2'b01, 0, 0, s, l, b);
    do_poll(2'b01, 0, 0, s, l, b);
    chk("t2_state_after2", {30'd0, key_state}, 0);
    do_poll(2'b01, 0, 0, s, l, b);
    chk("t2_state_after3", {30'd0, key_state}, 1);
    chk("t2_rise_cnt", rise_cnt, 1);
    chk("t2_rise_val", {30'd0, last_rise}, 1);
    chk("t2_fall_cnt", fall_cnt, 0);

    // 3. toggling data never settles
    for (int i = 0; i < 4; i++) do_poll((i % 2 == 0) ? 2'b11 : 2'b01, 0, 0, s, l, b);
    chk("t3_state", {30'd0, key_state}, 1);
    chk("t3_pulses", rise_cnt + fall_cnt, 1);

    // 4. third read of 10 stalled 5 cycles
    do_poll(2'b10, 0, 0, s, l, b);
    do_poll(2'b10, 0, 0, s, l, b);
    chk("t4_state_pre", {30'd0, key_state}, 1);
    do_poll(2'b10, 5, 0, s, l, b);
    chk("t4_read_len", l, 6);
    chk("t4_busy_len", b, 8);
    chk("t4_state", {30'd0, key_state}, 2);
    chk("t4_rise", {30'd0, last_rise}, 2);
    chk("t4_fall", {30'd0, last_fall}, 1);
    chk("t4_counts", (rise_cnt << 8) | fall_cnt, (2 << 8) | 1);
    prev_s = s;

    // 5. enable dropped in the acceptance cycle of the third 11 read
    do_poll(2'b11, 0, 0, s, l, b);
    chk("t4_tick_dropped", s - prev_s, 16);
    do_poll(2'b11, 0, 0, s, l, b);
    do_poll(2'b11, 0, 1, s, l, b);
    chk("t5_len", l, 1);
    chk("t5_state", {30'd0, key_state}, 3);
    chk("t5_rise", {30'd0, last_rise}, 1);
    chk("t5_fall_cnt", fall_cnt, 1);
    rs = read_starts;
    for (int i = 0; i < 20; i++) step();
    chk("t5_no_reads", read_starts, rs);
    enable = 1'b1;
    en_cyc = cyc;
    do_poll(2'b00, 0, 0, s, l, b);
    chk("t5_reenable", s - en_cyc, 8);
    do_poll(2'b00, 0, 0, s, l, b);
    do_poll(2'b00, 0, 0, s, l, b);
    chk("t5_state_00", {30'd0, key_state}, 0);
    chk("t5_fall_11", {30'd0, last_fall}, 3);
    chk("t5_fall_cnt2", fall_cnt, 2);

`ifdef KEY_POLL_TIMEOUT_EN
    // 6. stuck waitrequest abandons the read
    do_poll(2'b01, 1000, 0, s, l, b);
    chk("t6_read_len", l, 4);
    chk("t6_err", {31'd0, timeout_err}, 1);
    chk("t6_state", {30'd0, key_state}, 0);
    do_poll(2'b00, 0, 0, s, l, b);
    chk("t6_err_sticky", {31'd0, timeout_err}, 1);
`endif

    // 7. reach 10, then reset in the middle of a stalled read
    for (int i = 0; i < 3; i++) do_poll(2'b10, 0, 0, s, l, b);
    chk("t7_state", {30'd0, key_state}, 2);
    chk("t7_rise_cnt", rise_cnt, 4);
    stall_cfg = 1000;
    begin
      int unsigned n = 0;
      while (!avm_if.avm_read && n < 40) begin step(); n++; end
    end
    chk("t7_in_read", {31'd0, avm_if.avm_read}, 1);
    reset_n = 1'b0;
    #1;
    chk("t7_async_read", {31'd0, avm_if.avm_read}, 0);
    chk("t7_async_outs", {27'd0, busy, key_state, key_rise[1] | key_fall[1], key_rise[0] | key_fall[0]}, 0);
`ifdef KEY_POLL_TIMEOUT_EN
    chk("t7_err_cleared", {31'd0, timeout_err}, 0);
`endif
    step();
    step();
    stall_cfg = 0;
    reset_n = 1'b1;
    en_cyc = cyc;
    do_poll(2'b01, 0, 0, s, l, b);
    chk("t7_restart", s - en_cyc, 8);
    chk("t7_restart_len", l, 1);
    chk("t7_restart_state", {30'd0, key_state}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
